// File: rtl/pwm_capture.sv
// PWM high-time / period capture with stuck-line detection.
// Optional deglitch filter: define PWM_CAPTURE_FILTER_EN.
module pwm_capture #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 1020
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] duty_count,
  output logic [CNT_W-1:0] period_count,
  output logic             valid,
  output logic             stuck_high,
  output logic             stuck_low
);

  // Period counter is wide enough to reach TIMEOUT and saturate above it.
  localparam int TW_RAW = $clog2(TIMEOUT + 2);
  localparam int TW     = (TW_RAW > CNT_W) ? TW_RAW : CNT_W;

  localparam logic [TW-1:0]    T_LIM  = TW'(TIMEOUT);
  localparam logic [TW-1:0]    P_MAX  = '1;
  localparam logic [CNT_W-1:0] C_MAX  = '1;
  localparam logic [TW-1:0]    C_MAXW = TW'(C_MAX);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_MEAS = 2'd2;

  logic [1:0]       sync_q, sync_d;
  logic             lvl_q, lvl_d;
  logic             lvl, rise;
  logic [1:0]       state_q, state_d;
  logic [TW-1:0]    per_q, per_d, per_inc;
  logic [CNT_W-1:0] high_q, high_d, high_inc;
  logic [CNT_W-1:0] duty_q, duty_d;
  logic [CNT_W-1:0] pout_q, pout_d;
  logic             valid_q, valid_d;
  logic             sh_q, sh_d;
  logic             sl_q, sl_d;

  assign sync_d = {sync_q[0], pwm_in};

`ifdef PWM_CAPTURE_FILTER_EN
  logic [1:0] hist_q, hist_d;

  assign hist_d = {hist_q[0], sync_q[1]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) hist_q <= '0;
    else       hist_q <= hist_d;
  end

  // Level follows the input only after three equal samples.
  always_comb begin
    lvl = lvl_q;
    if (sync_q[1] == hist_q[0] && hist_q[0] == hist_q[1])
      lvl = sync_q[1];
  end
`else
  assign lvl = sync_q[1];
`endif

  assign lvl_d    = lvl;
  assign rise     = lvl & ~lvl_q;
  assign per_inc  = (per_q == P_MAX) ? per_q : per_q + 1'b1;
  assign high_inc = (high_q == C_MAX) ? high_q : high_q + 1'b1;

  always_comb begin
    state_d = state_q;
    per_d   = per_q;
    high_d  = high_q;
    duty_d  = duty_q;
    pout_d  = pout_q;
    valid_d = 1'b0;
    sh_d    = sh_q;
    sl_d    = sl_q;
    case (state_q)
      S_IDLE: begin
        per_d  = '0;
        high_d = '0;
        if (enable) state_d = S_WAIT;
      end
      S_WAIT, S_MEAS: begin
        per_d = per_inc;
        if (state_q == S_MEAS && lvl) high_d = high_inc;
        if (rise) begin
          if (state_q == S_MEAS) begin
            duty_d  = high_q;
            pout_d  = (per_q > C_MAXW) ? C_MAX : per_q[CNT_W-1:0];
            valid_d = 1'b1;
          end
          per_d   = TW'(1);
          high_d  = CNT_W'(1);
          sh_d    = 1'b0;
          sl_d    = 1'b0;
          state_d = S_MEAS;
        end else if (per_q == T_LIM) begin
          duty_d  = lvl ? C_MAX : '0;
          pout_d  = '0;
          valid_d = 1'b1;
          sh_d    = lvl;
          sl_d    = ~lvl;
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Disable overrides everything, including a same-cycle rise.
    if (!enable) begin
      state_d = S_IDLE;
      per_d   = '0;
      high_d  = '0;
      duty_d  = duty_q;
      pout_d  = pout_q;
      valid_d = 1'b0;
      sh_d    = sh_q;
      sl_d    = sl_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      lvl_q   <= 1'b0;
      state_q <= S_IDLE;
      per_q   <= '0;
      high_q  <= '0;
      duty_q  <= '0;
      pout_q  <= '0;
      valid_q <= 1'b0;
      sh_q    <= 1'b0;
      sl_q    <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      lvl_q   <= lvl_d;
      state_q <= state_d;
      per_q   <= per_d;
      high_q  <= high_d;
      duty_q  <= duty_d;
      pout_q  <= pout_d;
      valid_q <= valid_d;
      sh_q    <= sh_d;
      sl_q    <= sl_d;
    end
  end

  assign duty_count   = duty_q;
  assign period_count = pout_q;
  assign valid        = valid_q;
  assign stuck_high   = sh_q;
  assign stuck_low    = sl_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: expected reports are queued
// from the driven waveform, a monitor pops them on each valid.
`timescale 1ns/1ps
module tb_pwm_capture;

  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 1020;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic             pwm_in = 1'b0;
  logic [CNT_W-1:0] duty_count;
  logic [CNT_W-1:0] period_count;
  logic             valid;
  logic             stuck_high;
  logic             stuck_low;

  pwm_capture #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock),
    .reset(reset),
    .enable(enable),
    .pwm_in(pwm_in),
    .duty_count(duty_count),
    .period_count(period_count),
    .valid(valid),
    .stuck_high(stuck_high),
    .stuck_low(stuck_low)
  );

  always #10 clock = ~clock;

  typedef struct packed {
    logic [7:0] duty;
    logic [7:0] per;
    logic       sh;
    logic       sl;
  } rep_t;

  rep_t sb_q[$];
  rep_t last_exp;
  int   vectors = 0;
  int   miscompares = 0;

  logic [7:0] mon_d = '0;
  logic [7:0] mon_p = '0;
  logic       mon_v = 1'b0;

  function automatic rep_t meas(int h, int p);
    rep_t r;
    r.duty = (h > 255) ? 8'd255 : 8'(h);
    r.per  = (p > 255) ? 8'd255 : 8'(p);
    r.sh   = 1'b0;
    r.sl   = 1'b0;
    return r;
  endfunction

  function automatic rep_t stuck(logic hi);
    rep_t r;
    r.duty = hi ? 8'd255 : 8'd0;
    r.per  = 8'd0;
    r.sh   = hi;
    r.sl   = ~hi;
    return r;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(rep_t r);
    sb_q.push_back(r);
    last_exp = r;
  endtask

  task automatic tick(int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic period(int h, int p);
    pwm_in = 1'b1;
    tick(h);
    pwm_in = 1'b0;
    tick(p - h);
  endtask

  task automatic start_scn();
    pwm_in = 1'b0;
    enable = 1'b1;
    tick(10);
  endtask

  task automatic finish_scn();
    pwm_in = 1'b1;
    tick(10);
    enable = 1'b0;
    tick(5);
    pwm_in = 1'b0;
    tick(10);
  endtask

  task automatic check_zero(string tag);
    check({tag, "_duty"}, 32'(duty_count), 0);
    check({tag, "_period"}, 32'(period_count), 0);
    check({tag, "_valid"}, 32'(valid), 0);
    check({tag, "_sh"}, 32'(stuck_high), 0);
    check({tag, "_sl"}, 32'(stuck_low), 0);
  endtask

  // Monitor: compare every valid against the queue, else check hold.
  initial begin
    rep_t e;
    forever begin
      @(posedge clock);
      #1;
      if (reset) begin
        mon_d = '0;
        mon_p = '0;
        mon_v = 1'b0;
      end else begin
        if (valid) begin
          check("valid_spacing", 32'(mon_v), 0);
          if (sb_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_valid: got duty %0d period %0d, none expected at %0t",
                     duty_count, period_count, $time);
          end else begin
            e = sb_q.pop_front();
            check("duty", 32'(duty_count), 32'(e.duty));
            check("period", 32'(period_count), 32'(e.per));
            check("stuck_high", 32'(stuck_high), 32'(e.sh));
            check("stuck_low", 32'(stuck_low), 32'(e.sl));
          end
        end else begin
          check("duty_hold", 32'(duty_count), 32'(mon_d));
          check("period_hold", 32'(period_count), 32'(mon_p));
        end
        mon_d = duty_count;
        mon_p = period_count;
        mon_v = valid;
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int h, p;
    tick(3);
    check_zero("reset");
    reset = 1'b0;
    tick(3);

    // Nominal 25/255 source
    start_scn();
    for (int i = 0; i < 4; i++) begin
      push(meas(25, 255));
      period(25, 255);
    end
    finish_scn();

    // Random periods, including saturating ones
    start_scn();
    for (int i = 0; i < 8; i++) begin
      h = $urandom_range(3, 280);
      p = h + $urandom_range(3, 60);
      push(meas(h, p));
      period(h, p);
    end
    finish_scn();

    // Enable falls in the same cycle the rise is seen
    start_scn();
    push(meas(10, 40));
    period(10, 40);
    period(10, 40);
    pwm_in = 1'b1;
`ifdef PWM_CAPTURE_FILTER_EN
    tick(4);
`else
    tick(2);
`endif
    enable = 1'b0;
    tick(20);
    check("en_drop_duty", 32'(duty_count), 32'(last_exp.duty));
    check("en_drop_period", 32'(period_count), 32'(last_exp.per));
    pwm_in = 1'b0;
    tick(10);

    // One-cycle glitch in the low phase
    start_scn();
    push(meas(10, 50));
`ifdef PWM_CAPTURE_FILTER_EN
    push(meas(10, 50));
`else
    push(meas(10, 25));
    push(meas(1, 25));
`endif
    push(meas(10, 50));
    period(10, 50);
    pwm_in = 1'b1;
    tick(10);
    pwm_in = 1'b0;
    tick(15);
    pwm_in = 1'b1;
    tick(1);
    pwm_in = 1'b0;
    tick(24);
    period(10, 50);
    finish_scn();

    // Stuck low: exactly one report over 3000 cycles
    start_scn();
    push(stuck(1'b0));
    tick(3000);
    enable = 1'b0;
    tick(5);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(3);

    // Stuck high, then a 13/100 waveform recovers
    pwm_in = 1'b1;
    tick(10);
    enable = 1'b1;
    push(stuck(1'b1));
    tick(1500);
    pwm_in = 1'b0;
    tick(87);
    for (int i = 0; i < 3; i++) begin
      push(meas(13, 100));
      period(13, 100);
    end
    finish_scn();

    // Reset mid-period, then two rises before the next report
    start_scn();
    for (int i = 0; i < 3; i++) begin
      push(meas(20, 60));
      period(20, 60);
    end
    pwm_in = 1'b1;
    tick(20);
    pwm_in = 1'b0;
    tick(20);
    reset = 1'b1;
    #1;
    check_zero("mid_reset");
    tick(1);
    reset = 1'b0;
    tick(20);
    for (int i = 0; i < 3; i++) begin
      push(meas(30, 70));
      period(30, 70);
    end
    finish_scn();

    tick(20);
    check("sb_drain", 32'(sb_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
